// File: rtl/ofdm_pkg.sv
// Shared constants and FSM state types for the OFDM IFFT reorder block.
//   N_SUBC   : default subcarriers per OFDM symbol
//   SAMPLE_W : default I/Q sample width
//   wr_state_e / rd_state_e : write-side and read-side FSM states
package ofdm_pkg;

    localparam int N_SUBC   = 64;
    localparam int SAMPLE_W = 16;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        FILL     = 1'b1
    } wr_state_e;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// Two-bank symbol buffer: simple dual-port RAM, one write port, one read port
// with a registered, enable-gated read (read data holds while re_i is low).
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address {bank, index}
//   wdata_i : write data {I, Q}
//   re_i    : read enable
//   raddr_i : read address {bank, index}
//   rdata_o : registered read data
module ofdm_pingpong_ram #(
    parameter int N  = 64,
    parameter int DW = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(2*N)-1:0]     waddr_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(2*N)-1:0]     raddr_i,
    output logic [DW-1:0]              rdata_o
);

    logic [DW-1:0] mem_q [2*N];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ofdm_ifft_reorder.sv
// Reorders one OFDM symbol from subcarrier order (-N/2..N/2-1) into IFFT
// natural order (fftshift) using a ping-pong buffer, with sop/eop framing.
//   clk, rst        : clock, synchronous active-high reset
//   en              : global enable, low freezes everything
//   i_in, q_in      : input sample, valid_in/sop_in framing, ready_out back
//   i_out, q_out    : output sample, valid_out/sop_out/eop_out, ready_in back
//   err_sync        : sticky framing-error flag
//
// Write FSM
//   state    | meaning
//   WAIT_SOP | waiting for first subcarrier; non-sop samples are dropped
//   FILL     | writing indices 1..N-1 into the current write bank
// Read FSM
//   state    | meaning
//   IDLE     | at index 0, fetch starts once the read bank is full
//   STREAM   | mid-symbol, fetching indices 1..N-1 (bank known full)
module ofdm_ifft_reorder
    import ofdm_pkg::*;
#(
    parameter int N     = N_SUBC,
    parameter int W     = SAMPLE_W,
    parameter bit SHIFT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] i_in,
    input  logic signed [W-1:0] q_in,
    input  logic                valid_in,
    input  logic                sop_in,
    output logic                ready_out,
    output logic signed [W-1:0] i_out,
    output logic signed [W-1:0] q_out,
    output logic                valid_out,
    output logic                sop_out,
    output logic                eop_out,
    input  logic                ready_in,
    output logic                err_sync
);

    localparam int             AW       = $clog2(N);
    localparam logic [AW-1:0]  IDX_LAST = AW'(N - 1);
    localparam logic [AW-1:0]  IDX_HALF = AW'(N / 2);

    // write side
    wr_state_e     wr_state_q, wr_state_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          err_q, err_d;
    logic [1:0]    full_q, full_d;
    logic          in_xfer;
    logic          wr_en;
    logic          full_set;
    logic [AW-1:0] wr_k;
    logic [AW:0]   ram_waddr;

    // read side
    rd_state_e     rd_state_q, rd_state_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          rd_bank_q, rd_bank_d;
    logic          fetch_en;
    logic          full_clr;
    logic          out_load;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_sop_q, s1_sop_d;
    logic          s1_eop_q, s1_eop_d;
    logic [2*W-1:0] ram_rdata;

    // output register
    logic                valid_out_q, sop_out_q, eop_out_q;
    logic signed [W-1:0] i_out_q, q_out_q;

    assign ready_out = en & ~full_q[wr_bank_q];
    assign in_xfer   = valid_in & ready_out;

    // ---------------- write FSM: next state ----------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        err_d      = err_q;
        if (in_xfer) begin
            unique case (wr_state_q)
                WAIT_SOP: begin
                    if (sop_in) begin
                        wr_idx_d   = AW'(1);
                        wr_state_d = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                FILL: begin
                    // In FILL the index is never 0, so a sop here always
                    // means the previous symbol was truncated.
                    if (sop_in) begin
                        wr_idx_d = AW'(1);
                        err_d    = 1'b1;
                    end else if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d   = '0;
                        wr_bank_d  = ~wr_bank_q;
                        wr_state_d = WAIT_SOP;
                    end else begin
                        wr_idx_d = wr_idx_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write FSM: outputs ----------------
    always_comb begin
        wr_en    = 1'b0;
        wr_k     = wr_idx_q;
        full_set = 1'b0;
        if (in_xfer) begin
            unique case (wr_state_q)
                WAIT_SOP: begin
                    wr_en = sop_in;
                    wr_k  = '0;
                end
                FILL: begin
                    wr_en    = 1'b1;
                    wr_k     = sop_in ? '0 : wr_idx_q;
                    full_set = ~sop_in & (wr_idx_q == IDX_LAST);
                end
                default: ;
            endcase
        end
    end

    assign ram_waddr = {wr_bank_q, (SHIFT ? (wr_k ^ IDX_HALF) : wr_k)};

    // ---------------- read FSM ----------------
    // Output register takes a new sample when empty or being accepted.
    assign out_load = en & (~valid_out_q | ready_in);

    always_comb begin
        fetch_en = 1'b0;
        full_clr = 1'b0;
        unique case (rd_state_q)
            IDLE:    fetch_en = en & full_q[rd_bank_q] & (~s1_valid_q | out_load);
            STREAM:  fetch_en = en & (~s1_valid_q | out_load);
            default: ;
        endcase
        // Bank is released as soon as its last word is in the read register.
        full_clr = fetch_en & (rd_idx_q == IDX_LAST);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_bank_d  = rd_bank_q;
        if (fetch_en) begin
            if (rd_idx_q == IDX_LAST) begin
                rd_idx_d   = '0;
                rd_bank_d  = ~rd_bank_q;
                rd_state_d = IDLE;
            end else begin
                rd_idx_d   = rd_idx_q + AW'(1);
                rd_state_d = STREAM;
            end
        end
    end

    // Stage tracking what the RAM read register currently holds.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sop_d   = s1_sop_q;
        s1_eop_d   = s1_eop_q;
        if (fetch_en) begin
            s1_valid_d = 1'b1;
            s1_sop_d   = (rd_state_q == IDLE);
            s1_eop_d   = (rd_idx_q == IDX_LAST);
        end else if (out_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Write and read never touch the same bank, so both updates can apply.
    always_comb begin
        full_d = full_q;
        if (full_set) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (full_clr) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= WAIT_SOP;
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            err_q       <= 1'b0;
            full_q      <= 2'b00;
            rd_state_q  <= IDLE;
            rd_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            valid_out_q <= 1'b0;
            sop_out_q   <= 1'b0;
            eop_out_q   <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_bank_q  <= wr_bank_d;
            err_q      <= err_d;
            full_q     <= full_d;
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_bank_q  <= rd_bank_d;
            s1_valid_q <= s1_valid_d;
            s1_sop_q   <= s1_sop_d;
            s1_eop_q   <= s1_eop_d;
            if (out_load) begin
                valid_out_q <= s1_valid_q;
                sop_out_q   <= s1_valid_q & s1_sop_q;
                eop_out_q   <= s1_valid_q & s1_eop_q;
                if (s1_valid_q) begin
                    i_out_q <= ram_rdata[2*W-1:W];
                    q_out_q <= ram_rdata[W-1:0];
                end
            end
        end
    end

    ofdm_pingpong_ram #(
        .N  (N),
        .DW (2 * W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (ram_waddr),
        .wdata_i ({i_in, q_in}),
        .re_i    (fetch_en),
        .raddr_i ({rd_bank_q, rd_idx_q}),
        .rdata_o (ram_rdata)
    );

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign valid_out = valid_out_q;
    assign sop_out   = sop_out_q;
    assign eop_out   = eop_out_q;
    assign err_sync  = err_q;

endmodule

// File: tb/tb_ofdm_ifft_reorder.sv
module tb_ofdm_ifft_reorder;
    import ofdm_pkg::*;

    localparam int N = N_SUBC;
    localparam int W = SAMPLE_W;

    logic clk = 1'b0;
    logic rst, en, valid_in, sop_in, ready_in;
    logic signed [W-1:0] i_in, q_in;

    logic ready_out, valid_out, sop_out, eop_out, err_sync;
    logic signed [W-1:0] i_out, q_out;
    logic ready_out0, valid_out0, sop_out0, eop_out0, err_sync0;
    logic signed [W-1:0] i_out0, q_out0;

    typedef struct packed {
        logic signed [W-1:0] i;
        logic signed [W-1:0] q;
        logic                sop;
        logic                eop;
    } smp_t;

    smp_t exp1[$];
    smp_t exp0[$];
    logic signed [W-1:0] part_i[$];
    logic signed [W-1:0] part_q[$];
    bit   in_sym = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   out_cnt = 0;

    ofdm_ifft_reorder #(.N(N), .W(W), .SHIFT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .i_in(i_in), .q_in(q_in),
        .valid_in(valid_in), .sop_in(sop_in), .ready_out(ready_out),
        .i_out(i_out), .q_out(q_out), .valid_out(valid_out),
        .sop_out(sop_out), .eop_out(eop_out), .ready_in(ready_in),
        .err_sync(err_sync)
    );

    ofdm_ifft_reorder #(.N(N), .W(W), .SHIFT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .i_in(i_in), .q_in(q_in),
        .valid_in(valid_in), .sop_in(sop_in), .ready_out(ready_out0),
        .i_out(i_out0), .q_out(q_out0), .valid_out(valid_out0),
        .sop_out(sop_out0), .eop_out(eop_out0), .ready_in(ready_in),
        .err_sync(err_sync0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: collect accepted samples into a symbol; a complete
    // symbol yields its fftshifted order (and its natural order for SHIFT=0).
    smp_t m1, m0;
    always @(negedge clk) begin
        if (rst) begin
            part_i.delete();
            part_q.delete();
            in_sym = 1'b0;
            exp1.delete();
            exp0.delete();
        end else if (en && valid_in && ready_out) begin
            if (sop_in) begin
                part_i.delete();
                part_q.delete();
                part_i.push_back(i_in);
                part_q.push_back(q_in);
                in_sym = 1'b1;
            end else if (in_sym) begin
                part_i.push_back(i_in);
                part_q.push_back(q_in);
            end
            if (part_i.size() == N) begin
                for (int j = 0; j < N; j++) begin
                    int s;
                    s = (j + N / 2) % N;
                    m1.i = part_i[s];  m1.q = part_q[s];
                    m1.sop = (j == 0); m1.eop = (j == N - 1);
                    exp1.push_back(m1);
                    m0.i = part_i[j];  m0.q = part_q[j];
                    m0.sop = (j == 0); m0.eop = (j == N - 1);
                    exp0.push_back(m0);
                end
                part_i.delete();
                part_q.delete();
                in_sym = 1'b0;
            end
        end
    end

    // Monitor for the fftshift instance, including stall stability.
    smp_t e1;
    logic [33:0] held;
    bit stall_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 64'({valid_out, i_out, q_out, sop_out, eop_out}),
                      64'({1'b1, held}));
            if (valid_out && ready_in && en) begin
                if (exp1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got i=%0d q=%0d with no expected sample", i_out, q_out);
                end else begin
                    e1 = exp1.pop_front();
                    check("out_word", 64'({i_out, q_out, sop_out, eop_out}), 64'(e1));
                end
                out_cnt++;
            end
            stall_prev = valid_out && !ready_in && en;
            held = {i_out, q_out, sop_out, eop_out};
        end
    end

    // Monitor for the pass-through instance.
    smp_t e0;
    always @(negedge clk) begin
        if (!rst && valid_out0 && ready_in && en) begin
            if (exp0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out0_unexpected: got i=%0d q=%0d with no expected sample", i_out0, q_out0);
            end else begin
                e0 = exp0.pop_front();
                check("out0_word", 64'({i_out0, q_out0, sop_out0, eop_out0}), 64'(e0));
            end
        end
    end

    task automatic send(input logic signed [W-1:0] si, input logic signed [W-1:0] sq, input bit ss);
        int budget;
        budget = 0;
        valid_in = 1'b1;
        i_in = si;
        q_in = sq;
        sop_in = ss;
        @(negedge clk);
        while (!ready_out && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!ready_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got ready_out=0, required 1 within 2000 cycles");
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sop_in = 1'b0;
    endtask

    task automatic send_rand_symbol(input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps && ($urandom % 3 == 0)) repeat ($urandom_range(1, 2)) @(posedge clk);
            #0;
            send(W'($urandom), W'($urandom), k == 0);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        ready_in = 1'b1;
        while ((exp1.size() != 0 || exp0.size() != 0 || valid_out || valid_out0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        check(name, 64'(budget < 2000), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; valid_in = 1'b0; sop_in = 1'b0;
        i_in = '0; q_in = '0; ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_outputs", 64'({valid_out, sop_out, eop_out, err_sync, ready_out}), 64'(5'b00001));
        check("rst_data", 64'({i_out, q_out}), 64'(0));

        // ramp symbol: i=k, q=-k, with latency check
        for (int k = 0; k < N; k++) send(W'(k), W'(-k), k == 0);
        @(posedge clk); #1;
        check("lat_edge1_valid", 64'(valid_out), 64'(0));
        @(posedge clk); #1;
        check("lat_edge2_valid_sop", 64'({valid_out, sop_out}), 64'(2'b11));
        check("first_i", 64'(i_out), 64'(W'(N / 2)));
        check("first_i_passthru", 64'(i_out0), 64'(0));
        drain("drain_ramp");
        check("err_clean", 64'({err_sync, err_sync0}), 64'(0));

        // three back-to-back symbols with the sink stalled for 150 cycles
        fork
            for (int s = 0; s < 3; s++) send_rand_symbol(1'b0);
            begin
                ready_in = 1'b0;
                repeat (150) @(posedge clk);
                #1 ready_in = 1'b1;
                begin
                    int c;
                    c = 0;
                    repeat (2 * N) begin
                        @(negedge clk);
                        if (valid_out && ready_in) c++;
                    end
                    check("no_gap_two_symbols", 64'(c), 64'(2 * N));
                end
            end
            begin
                repeat (140) @(posedge clk);
                #2;
                check("ready_low_both_full", 64'(ready_out), 64'(0));
            end
        join
        drain("drain_b2b");

        // random valid gaps and random sink backpressure
        fork
            for (int s = 0; s < 3; s++) send_rand_symbol(1'b1);
            begin
                repeat (700) begin
                    @(posedge clk);
                    #1 ready_in = 1'($urandom % 2);
                end
                ready_in = 1'b1;
            end
        join
        drain("drain_random");
        check("err_clean_random", 64'({err_sync, err_sync0}), 64'(0));

        // enable low forces ready_out low and blocks transfers
        @(posedge clk); #1;
        en = 1'b0; valid_in = 1'b1; sop_in = 1'b1; i_in = 16'sd7; q_in = 16'sd7;
        #1 check("en_low_ready", 64'(ready_out), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("en_low_err_hold", 64'(err_sync), 64'(0));
        en = 1'b1; valid_in = 1'b0; sop_in = 1'b0;

        // truncated symbol (sop again at k=20) followed by a full symbol
        for (int k = 0; k < 20; k++) send(W'(1000 + k), W'(-1000 - k), k == 0);
        send_rand_symbol(1'b0);
        check("err_after_resop", 64'({err_sync, err_sync0}), 64'(2'b11));
        drain("drain_resop");

        // reset in the middle of output streaming
        send_rand_symbol(1'b0);
        begin
            int base, b;
            base = out_cnt;
            b = 0;
            while (out_cnt < base + 10 && b < 1000) begin
                @(negedge clk);
                #1;
                b++;
            end
            check("reach_mid_output", 64'(out_cnt >= base + 10), 64'(1));
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_state", 64'({valid_out, sop_out, eop_out, ready_out, err_sync}), 64'(5'b00010));
        check("midrst_data", 64'({i_out, q_out}), 64'(0));
        repeat (20) @(posedge clk);

        // leading samples without sop are dropped, then a good symbol
        for (int k = 0; k < 3; k++) send(W'(500 + k), W'(500 + k), 1'b0);
        check("err_after_drop", 64'({err_sync, err_sync0}), 64'(2'b11));
        send_rand_symbol(1'b1);
        drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
